// File: rtl/sram_responder_if.sv
// sram_responder_if: SRAM control pins and status outputs shared by the memory stage and sram_responder
interface sram_responder_if #(parameter int ADDR_WIDTH = 18);
  logic [ADDR_WIDTH-1:0] SRAM_ADDR;
  logic SRAM_UB_N;
  logic SRAM_LB_N;
  logic SRAM_WE_N;
  logic SRAM_CE_N;
  logic SRAM_OE_N;
  logic rd_valid;
  logic [15:0] read_count;
  logic [15:0] write_count;
  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
    input rd_valid, read_count, write_count
  );
  modport slave (
    input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
    output rd_valid, read_count, write_count
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: clocked 16-bit async SRAM model with programmable read latency on a shared DQ bus
// Optional access counters are built when SRAM_RESPONDER_STATS_EN is defined.
module sram_responder #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int READ_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  sram_responder_if.slave bus,
  inout wire [DATA_WIDTH-1:0] SRAM_DQ
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_data;
  logic [IW-1:0] r_prev;
  logic [2:0] r_cnt;
  logic [IW-1:0] w_idx;
  logic w_wr, w_rd, w_hit, w_drv, w_ub, w_lb;
  wire w_unused = ^bus.SRAM_ADDR;
  always_comb begin
    w_idx = bus.SRAM_ADDR[IW-1:0];
    w_wr = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
    w_rd = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
    w_hit = r_cnt != 3'd0 && r_prev == w_idx;
    // live pin and address qualification keeps stale or turnaround data off the bus
    w_drv = w_rd && w_hit && r_cnt >= LAT;
    w_ub = w_drv && !bus.SRAM_UB_N;
    w_lb = w_drv && !bus.SRAM_LB_N;
  end
  assign SRAM_DQ[15:8] = w_ub ? r_data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0] = w_lb ? r_data[7:0] : 8'hzz;
  assign bus.rd_valid = w_ub || w_lb;
  always_ff @(posedge clk)
    if (w_wr) begin
      if (!bus.SRAM_UB_N) r_mem[w_idx][15:8] <= SRAM_DQ[15:8];
      if (!bus.SRAM_LB_N) r_mem[w_idx][7:0] <= SRAM_DQ[7:0];
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt <= 3'd0;
      r_data <= 16'd0;
      r_prev <= '0;
    end else if (w_rd) begin
      r_data <= r_mem[w_idx];
      r_prev <= w_idx;
      r_cnt <= !w_hit ? 3'd1 : r_cnt == 3'd7 ? 3'd7 : r_cnt + 3'd1;
    end else
      r_cnt <= 3'd0;
`ifdef SRAM_RESPONDER_STATS_EN
  logic r_vld;
  logic [15:0] r_rc, r_wc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_vld <= 1'b0;
      r_rc <= 16'd0;
      r_wc <= 16'd0;
    end else begin
      r_vld <= bus.rd_valid;
      if (bus.rd_valid && !r_vld) r_rc <= r_rc + 16'd1;
      if (w_wr && !(bus.SRAM_UB_N && bus.SRAM_LB_N)) r_wc <= r_wc + 16'd1;
    end
  assign bus.read_count = r_rc;
  assign bus.write_count = r_wc;
`else
  assign bus.read_count = 16'd0;
  assign bus.write_count = 16'd0;
`endif
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed and randomized checks of sram_responder against a word-array reference model
module tb_sram_responder;
  localparam int AW = 18;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  tri1 [15:0] dq;
  logic [15:0] tb_dq = 16'h0000;
  logic tb_drv = 1'b0;
  logic [15:0] m [DEPTH];
  int checks = 0;
  int fails = 0;
  int ra, rh;
  logic rub, rlb;
  assign dq = tb_drv ? tb_dq : 16'hzzzz;
  sram_responder_if #(.ADDR_WIDTH(AW)) bus();
  sram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1;
    bus.SRAM_UB_N = 1'b1;
    bus.SRAM_LB_N = 1'b1;
    tb_drv = 1'b0;
  endtask
  // an undriven lane reads back as all ones through the bus pull-up
  function automatic logic [15:0] lanes(logic [15:0] w, logic ub_n, logic lb_n);
    return {ub_n ? 8'hFF : w[15:8], lb_n ? 8'hFF : w[7:0]};
  endfunction
  task automatic chk(string tag, logic [15:0] ed, logic ev);
    #1;
    checks++;
    assert (dq === ed && bus.rd_valid === ev) else begin
      fails++;
      $error("FAIL %s: dq=%h rd_valid=%b, expected dq=%h rd_valid=%b", tag, dq, bus.rd_valid, ed, ev);
    end
  endtask
  task automatic chkc(string tag, logic [15:0] o, logic [15:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, o, e);
    end
  endtask
  task automatic wr(int a, logic [15:0] d, logic ub_n, logic lb_n);
    bus.SRAM_ADDR = AW'(a);
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b0;
    bus.SRAM_OE_N = 1'b1;
    bus.SRAM_UB_N = ub_n;
    bus.SRAM_LB_N = lb_n;
    tb_dq = d;
    tb_drv = 1'b1;
    tick();
    if (!ub_n) m[a % DEPTH][15:8] = d[15:8];
    if (!lb_n) m[a % DEPTH][7:0] = d[7:0];
    idle();
  endtask
  task automatic rd(int a, logic ub_n, logic lb_n);
    bus.SRAM_ADDR = AW'(a);
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_OE_N = 1'b0;
    bus.SRAM_UB_N = ub_n;
    bus.SRAM_LB_N = lb_n;
    tb_drv = 1'b0;
  endtask
  initial begin
    idle();
    bus.SRAM_ADDR = '0;
    repeat (2) tick();
    chk("reset_idle", 16'hFFFF, 1'b0);
    chkc("reset_read_count", bus.read_count, 16'd0);
    chkc("reset_write_count", bus.write_count, 16'd0);
    rst = 1'b1;
    tick();
    wr(5, 16'hBEEF, 1'b0, 1'b0);
    wr(4, 16'h5A5A, 1'b0, 1'b0);
    rd(5, 1'b0, 1'b0);
    chk("rd_before_edge", 16'hFFFF, 1'b0);
    tick();
    chk("rd_after_edge1", 16'hFFFF, 1'b0);
    tick();
    chk("rd_after_edge2", 16'hBEEF, 1'b1);
    tick();
    chk("rd_hold", 16'hBEEF, 1'b1);
    idle();
    chk("rd_release", 16'hFFFF, 1'b0);
    tick();
    wr(5, 16'h1234, 1'b0, 1'b1);
    rd(5, 1'b0, 1'b0);
    tick();
    tick();
    chk("byte_merge", 16'h12EF, 1'b1);
    bus.SRAM_LB_N = 1'b1;
    chk("byte_upper_only", 16'h12FF, 1'b1);
    idle();
    tick();
    wr(3, 16'h00AA, 1'b0, 1'b0);
    rd(1027, 1'b0, 1'b0);
    tick();
    tick();
    chk("addr_wrap", 16'h00AA, 1'b1);
    bus.SRAM_ADDR = AW'(4);
    chk("addr_change", 16'hFFFF, 1'b0);
    tick();
    chk("addr_change_edge1", 16'hFFFF, 1'b0);
    tick();
    chk("addr_change_edge2", 16'h5A5A, 1'b1);
    bus.SRAM_OE_N = 1'b1;
    chk("oe_release", 16'hFFFF, 1'b0);
    bus.SRAM_OE_N = 1'b0;
    chk("oe_restore", 16'h5A5A, 1'b1);
    tick();
    bus.SRAM_CE_N = 1'b1;
    chk("ce_release", 16'hFFFF, 1'b0);
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b0;
    tb_dq = 16'h7777;
    tb_drv = 1'b1;
    chk("we_no_drive", 16'h7777, 1'b0);
    tick();
    m[4] = 16'h7777;
    rd(4, 1'b0, 1'b0);
    chk("after_write", 16'hFFFF, 1'b0);
    tick();
    tick();
    chk("read_after_write", 16'h7777, 1'b1);
    idle();
    tick();
    rd(5, 1'b0, 1'b0);
    tick();
    tick();
    chk("pre_reset_read", 16'h12EF, 1'b1);
    rst = 1'b0;
    chk("reset_mid_read", 16'hFFFF, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("post_reset_read", 16'h12EF, 1'b1);
    idle();
    tick();
    for (int a = 0; a < 8; a++) wr(a, 16'($urandom), 1'b0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      ra = $urandom_range(0, 7) + DEPTH * $urandom_range(0, 3);
      rub = 1'($urandom);
      rlb = 1'($urandom);
      if ($urandom_range(0, 2) == 0) wr(ra, 16'($urandom), rub, rlb);
      else begin
        rh = $urandom_range(1, 4);
        rd(ra, rub, rlb);
        chk("rnd_before_edge", 16'hFFFF, 1'b0);
        for (int j = 1; j <= rh; j++) begin
          tick();
          chk("rnd_read", j >= LAT ? lanes(m[ra % DEPTH], rub, rlb) : 16'hFFFF, j >= LAT && !(rub && rlb));
        end
        idle();
        tick();
      end
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    wr(10, 16'h0101, 1'b0, 1'b0);
    wr(11, 16'h0202, 1'b0, 1'b1);
    wr(12, 16'h0303, 1'b1, 1'b0);
    for (int r = 10; r < 12; r++) begin
      rd(r, 1'b0, 1'b0);
      repeat (3) tick();
      idle();
      tick();
    end
`ifdef SRAM_RESPONDER_STATS_EN
    chkc("stats_write_count", bus.write_count, 16'd3);
    chkc("stats_read_count", bus.read_count, 16'd2);
`else
    chkc("stats_write_count", bus.write_count, 16'd0);
    chkc("stats_read_count", bus.read_count, 16'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
